linear_engine_arb: RTL and testbench

Round-robin arbiter and launcher that time-shares the single linear/matmul engine between the transformer-block stages that need it: Q/K/V/output projection, FFN1 and FFN2. Each requester holds a level request plus its matrix dimensions and weight base. The arbiter picks one requester, latches its configuration onto the engine, pulses the engine start and waits for completion. It then returns a one-cycle done to the winner. A watchdog aborts any job that exceeds a cycle budget.

---
 rtl/linear_arb_pkg.sv | 31 +++
 rtl/linear_engine_arb_rr_pick.sv | 33 +++
 rtl/linear_engine_arb.sv | 141 ++++++++++++++
 tb/tb_linear_engine_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_arb_pkg.sv
// Shared types for the linear-engine arbiter: FSM states, requester ids and
// the per-job engine configuration record.
package linear_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } state_t;

    localparam int REQ_PROJ = 0;
    localparam int REQ_FFN1 = 1;
    localparam int REQ_FFN2 = 2;

    localparam int CFG_DIM_W  = 12;
    localparam int CFG_ADDR_W = 20;

    typedef struct packed {
        logic [CFG_DIM_W-1:0]  m;
        logic [CFG_DIM_W-1:0]  k;
        logic [CFG_DIM_W-1:0]  n;
        logic [CFG_ADDR_W-1:0] wbase;
    } cfg_t;

    // Round-robin successor of a requester index.
    function automatic logic [1:0] next_idx(input logic [1:0] idx, input int nreq);
        return (int'(idx) >= nreq - 1) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/linear_engine_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] idx
);

    int cand;

    // Scan from the farthest offset down so the nearest one to ptr wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        cand   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NREQ;
            if (req[cand]) begin
                valid        = 1'b1;
                winner       = '0;
                winner[cand] = 1'b1;
                idx          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/linear_engine_arb.sv
// Time-shares the linear/matmul engine between projection, FFN1 and FFN2:
// round-robin grant, config latch, start pulse, completion and watchdog abort.
module linear_engine_arb
    import linear_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DIM_W  = 12,
    parameter int ADDR_W = 20,
    parameter int WDOG_W = 20
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DIM_W-1:0]  req_m,
    input  logic [NREQ*DIM_W-1:0]  req_k,
    input  logic [NREQ*DIM_W-1:0]  req_n,
    input  logic [NREQ*ADDR_W-1:0] req_wbase,
    output logic [NREQ-1:0]        req_done,
    output logic [NREQ-1:0]        grant,
    output logic                   eng_start,
    output logic [DIM_W-1:0]       eng_m,
    output logic [DIM_W-1:0]       eng_k,
    output logic [DIM_W-1:0]       eng_n,
    output logic [ADDR_W-1:0]      eng_wbase,
    input  logic                   eng_done,
    output logic                   eng_abort,
    output logic                   err,
    output logic [1:0]             err_id,
    input  logic                   err_clr
);

    localparam int PTR_W = 2;
    localparam logic [WDOG_W-1:0] WDOG_LAST = {WDOG_W{1'b1}} - WDOG_W'(1);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [WDOG_W-1:0] wdog;

    logic              pick_valid;
    logic [NREQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]  pick_idx;
    cfg_t              pick_cfg;
    int                sel;
    logic              timeout;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_cfg                     = '0;
        sel                          = int'(pick_idx);
        pick_cfg.m[DIM_W-1:0]        = req_m[sel*DIM_W +: DIM_W];
        pick_cfg.k[DIM_W-1:0]        = req_k[sel*DIM_W +: DIM_W];
        pick_cfg.n[DIM_W-1:0]        = req_n[sel*DIM_W +: DIM_W];
        pick_cfg.wbase[ADDR_W-1:0]   = req_wbase[sel*ADDR_W +: ADDR_W];
    end

    // A coincident eng_done takes priority over watchdog expiry.
    assign timeout = (state == RUN) && !eng_done && (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            wdog      <= '0;
            grant     <= '0;
            req_done  <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            eng_m     <= '0;
            eng_k     <= '0;
            eng_n     <= '0;
            eng_wbase <= '0;
        end else begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            req_done  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        eng_m     <= pick_cfg.m[DIM_W-1:0];
                        eng_k     <= pick_cfg.k[DIM_W-1:0];
                        eng_n     <= pick_cfg.n[DIM_W-1:0];
                        eng_wbase <= pick_cfg.wbase[ADDR_W-1:0];
                        grant     <= pick_onehot;
                        win_idx   <= pick_idx;
                        eng_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (eng_done) begin
                        req_done <= grant;
                        state    <= RETIRE;
                    end else if (timeout) begin
                        req_done  <= grant;
                        eng_abort <= 1'b1;
                        state     <= RETIRE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                RETIRE: begin
                    ptr   <= next_idx(win_idx, NREQ);
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err    <= 1'b0;
            err_id <= '0;
        end else if (timeout) begin
            err    <= 1'b1;
            err_id <= win_idx;
        end else if (err_clr) begin
            err    <= 1'b0;
            err_id <= '0;
        end
    end

endmodule

// File: tb/tb_linear_engine_arb.sv
// Directed bench for linear_engine_arb: single job, contention order,
// fairness, watchdog abort, done-at-expiry and reset mid-job.
module tb_linear_engine_arb;
    import linear_arb_pkg::*;

    localparam int NREQ   = 3;
    localparam int DIM_W  = 12;
    localparam int ADDR_W = 20;
    localparam int WDOG_W = 4;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*DIM_W-1:0]  req_m = '0;
    logic [NREQ*DIM_W-1:0]  req_k = '0;
    logic [NREQ*DIM_W-1:0]  req_n = '0;
    logic [NREQ*ADDR_W-1:0] req_wbase = '0;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        grant;
    logic                   eng_start;
    logic [DIM_W-1:0]       eng_m, eng_k, eng_n;
    logic [ADDR_W-1:0]      eng_wbase;
    logic                   eng_done = 1'b0;
    logic                   eng_abort;
    logic                   err;
    logic [1:0]             err_id;
    logic                   err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [DIM_W-1:0]  exp_m  [NREQ];
    logic [DIM_W-1:0]  exp_k  [NREQ];
    logic [DIM_W-1:0]  exp_n  [NREQ];
    logic [ADDR_W-1:0] exp_wb [NREQ];

    linear_engine_arb #(
        .NREQ   (NREQ),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_m     (req_m),
        .req_k     (req_k),
        .req_n     (req_n),
        .req_wbase (req_wbase),
        .req_done  (req_done),
        .grant     (grant),
        .eng_start (eng_start),
        .eng_m     (eng_m),
        .eng_k     (eng_k),
        .eng_n     (eng_n),
        .eng_wbase (eng_wbase),
        .eng_done  (eng_done),
        .eng_abort (eng_abort),
        .err       (err),
        .err_id    (err_id),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"},     32'(grant),     32'h0);
        chk({tag, "_req_done"},  32'(req_done),  32'h0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'h0);
        chk({tag, "_eng_abort"}, 32'(eng_abort), 32'h0);
        chk({tag, "_eng_m"},     32'(eng_m),     32'h0);
        chk({tag, "_eng_k"},     32'(eng_k),     32'h0);
        chk({tag, "_eng_n"},     32'(eng_n),     32'h0);
        chk({tag, "_eng_wbase"}, 32'(eng_wbase), 32'h0);
        chk({tag, "_err"},       32'(err),       32'h0);
        chk({tag, "_err_id"},    32'(err_id),    32'h0);
    endtask

    // Waits (bounded) for LAUNCH, checks the grant and latched config, runs the
    // engine for run_cycles RUN cycles, then checks the completion pulse.
    task automatic run_job(input string tag, input logic [NREQ-1:0] exp_grant,
                           input logic [NREQ-1:0] drop, input int run_cycles);
        int n;
        int w;
        n = 0;
        while (eng_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        w = idx_of(exp_grant);
        chk({tag, "_start"},  32'(eng_start), 32'h1);
        chk({tag, "_grant"},  32'(grant),     32'(exp_grant));
        chk({tag, "_eng_m"},  32'(eng_m),     32'(exp_m[w]));
        chk({tag, "_eng_k"},  32'(eng_k),     32'(exp_k[w]));
        chk({tag, "_eng_n"},  32'(eng_n),     32'(exp_n[w]));
        chk({tag, "_wbase"},  32'(eng_wbase), 32'(exp_wb[w]));
        tick();
        chk({tag, "_start_1cyc"}, 32'(eng_start), 32'h0);
        repeat (run_cycles - 1) tick();
        eng_done = 1'b1;
        chk({tag, "_no_early_done"}, 32'(req_done), 32'h0);
        tick();
        eng_done = 1'b0;
        chk({tag, "_req_done"}, 32'(req_done),  32'(exp_grant));
        chk({tag, "_no_abort"}, 32'(eng_abort), 32'h0);
        req = req & ~drop;
        tick();
        chk({tag, "_grant_clr"}, 32'(grant), 32'h0);
    endtask

    initial begin
        exp_m[REQ_PROJ] = 12'd64;  exp_k[REQ_PROJ] = 12'd128; exp_n[REQ_PROJ] = 12'd64;  exp_wb[REQ_PROJ] = 20'h00100;
        exp_m[REQ_FFN1] = 12'd32;  exp_k[REQ_FFN1] = 12'd48;  exp_n[REQ_FFN1] = 12'd80;  exp_wb[REQ_FFN1] = 20'h02000;
        exp_m[REQ_FFN2] = 12'd7;   exp_k[REQ_FFN2] = 12'd9;   exp_n[REQ_FFN2] = 12'd11;  exp_wb[REQ_FFN2] = 20'hABCDE;
        for (int i = 0; i < NREQ; i++) begin
            req_m[i*DIM_W +: DIM_W]      = exp_m[i];
            req_k[i*DIM_W +: DIM_W]      = exp_k[i];
            req_n[i*DIM_W +: DIM_W]      = exp_n[i];
            req_wbase[i*ADDR_W +: ADDR_W] = exp_wb[i];
        end

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Single job; config change during the job must not reach eng_*
        req = 3'b001;
        tick();
        chk("single_start", 32'(eng_start), 32'h1);
        chk("single_grant", 32'(grant),     32'h1);
        chk("single_eng_m", 32'(eng_m),     32'd64);
        chk("single_wbase", 32'(eng_wbase), 32'h100);
        req_m[0 +: DIM_W] = 12'd5;
        tick();
        chk("single_start_1cyc", 32'(eng_start), 32'h0);
        repeat (9) tick();
        eng_done = 1'b1;
        chk("single_no_early_done", 32'(req_done), 32'h0);
        tick();
        eng_done = 1'b0;
        chk("single_req_done", 32'(req_done), 32'h1);
        chk("single_hold_m",   32'(eng_m),    32'd64);
        chk("single_abort",    32'(eng_abort), 32'h0);
        req = 3'b000;
        req_m[0 +: DIM_W] = exp_m[0];
        tick();
        chk("single_done_1cyc", 32'(req_done), 32'h0);
        chk("single_grant_clr", 32'(grant),    32'h0);

        // Contention with ptr = 1
        req = 3'b111;
        run_job("cont_p1_a", 3'b010, 3'b010, 3);
        run_job("cont_p1_b", 3'b100, 3'b100, 3);
        run_job("cont_p1_c", 3'b001, 3'b001, 3);

        // Move ptr to 0, then contention with ptr = 0
        req = 3'b100;
        run_job("ptr_move", 3'b100, 3'b100, 2);
        req = 3'b111;
        run_job("cont_p0_a", 3'b001, 3'b001, 3);
        run_job("cont_p0_b", 3'b010, 3'b010, 3);
        run_job("cont_p0_c", 3'b100, 3'b100, 3);

        // Fairness: req[0] stays high, req[2] rises during job 0
        req = 3'b001;
        tick();
        req = 3'b101;
        run_job("fair_job0", 3'b001, 3'b000, 4);
        run_job("fair_job2", 3'b100, 3'b100, 4);
        run_job("fair_job0b", 3'b001, 3'b001, 2);

        // Watchdog expiry (ptr = 1)
        req = 3'b010;
        tick();
        chk("wdog_start", 32'(eng_start), 32'h1);
        repeat (15) tick();
        chk("wdog_no_early_abort", 32'(eng_abort), 32'h0);
        chk("wdog_no_early_done",  32'(req_done),  32'h0);
        tick();
        chk("wdog_abort",    32'(eng_abort), 32'h1);
        chk("wdog_req_done", 32'(req_done),  32'h2);
        chk("wdog_err",      32'(err),       32'h1);
        chk("wdog_err_id",   32'(err_id),    32'h1);
        req = 3'b000;
        tick();
        chk("wdog_abort_1cyc", 32'(eng_abort), 32'h0);
        chk("wdog_err_sticky", 32'(err),       32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wdog_err_clr",    32'(err),    32'h0);
        chk("wdog_err_id_clr", 32'(err_id), 32'h0);

        // Reset mid-RUN while ptr = 2
        req = 3'b001;
        tick();
        chk("rst_launch", 32'(eng_start), 32'h1);
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        req = 3'b000;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_req_done", 32'(req_done),  32'h0);
            chk("rst_no_abort",    32'(eng_abort), 32'h0);
        end
        req = 3'b111;
        run_job("rst_ptr0_a", 3'b001, 3'b001, 2);
        run_job("rst_ptr0_b", 3'b010, 3'b010, 2);
        run_job("rst_ptr0_c", 3'b100, 3'b100, 2);

        // eng_done on the cycle the watchdog would expire
        req = 3'b100;
        tick();
        chk("edge_start", 32'(eng_start), 32'h1);
        repeat (15) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("edge_no_abort", 32'(eng_abort), 32'h0);
        chk("edge_req_done", 32'(req_done),  32'h4);
        chk("edge_no_err",   32'(err),       32'h0);
        req = 3'b000;
        tick();
        chk("edge_idle_err", 32'(err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
